// File: rtl/sam_decoder_p.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sam_decoder_p                                                   |
// | Purpose  : serial-configured majority decoder emitting masked key words    |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module sam_decoder_p #(
  parameter int KEY_W      = 32,
  parameter int N_W        = 4,
  parameter int MIN_PERIOD = 10,
  parameter int MAX_PERIOD = 60,
  parameter int CNT_W      = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mode,
  input  logic             str,
  output logic [KEY_W-1:0] msg,
  output logic             msg_valid,
  input  logic             msg_ready,
  output logic             bit_out,
  output logic             frame,
  output logic             configured,
  output logic             overflow,
  output logic             timeout
);

  localparam int               c_LOG     = $clog2(KEY_W);
  localparam int               c_LW      = $clog2(KEY_W + 1);
  localparam int               c_CW      = $clog2(KEY_W + N_W + 1);
  localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
  localparam logic [CNT_W-1:0] c_MIN     = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0] c_MAX     = CNT_W'(MAX_PERIOD);

  typedef enum logic [2:0] {
    S_CFG_N    = 3'd0,
    S_CFG_KEY  = 3'd1,
    S_CFG_MASK = 3'd2,
    S_SYNC     = 3'd3,
    S_RX       = 3'd4,
    S_RESYNC   = 3'd5
  } state_t;

  state_t           r_state, w_next;
  logic [N_W-1:0]   r_n;
  logic [KEY_W-1:0] r_d, r_caps;
  logic [c_CW-1:0]  r_cfg_cnt;
  logic [CNT_W-1:0] r_period, r_ones, r_zeros;
  logic             r_prev;

  logic [c_LW-1:0]  w_len;
  logic [KEY_W-1:0] w_mask, w_word;
  logic             w_cfg_last, w_run, w_edge, w_qual, w_tout, w_bit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == c_CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    w_len      = (int'(r_n) >= c_LOG) ? c_LW'(KEY_W) : (c_LW'(1) << r_n);
    w_mask     = ~({KEY_W{1'b1}} << w_len);
    w_cfg_last = (r_state == S_CFG_N) ? (r_cfg_cnt == c_CW'(N_W - 1))
                                      : (r_cfg_cnt == c_CW'(w_len) - c_CW'(1));
    w_run      = !mode && (r_state == S_SYNC || r_state == S_RX || r_state == S_RESYNC);
    w_edge     = !r_prev && str;
    w_qual     = w_run && (r_state == S_RX) && w_edge && (r_period >= c_MIN);
    w_tout     = w_run && (r_state == S_RX) && !w_qual && (r_period == c_MAX);
    w_bit      = r_ones > r_zeros;
    w_word     = (w_bit ? (~r_d | r_caps) : (r_d | r_caps)) & w_mask;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_CFG_N:    if (mode && w_cfg_last) w_next = S_CFG_KEY;
      S_CFG_KEY:  if (mode && w_cfg_last) w_next = S_CFG_MASK;
      S_CFG_MASK: if (mode && w_cfg_last) w_next = S_SYNC;
      S_SYNC, S_RESYNC: begin
        if (mode)        w_next = S_CFG_N;
        else if (w_edge) w_next = S_RX;
      end
      S_RX: begin
        if (mode)        w_next = S_CFG_N;
        else if (w_tout) w_next = S_RESYNC;
      end
      default:           w_next = S_CFG_N;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_CFG_N;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_n        <= '0;
      r_d        <= '0;
      r_caps     <= '0;
      r_cfg_cnt  <= '0;
      r_period   <= '0;
      r_ones     <= '0;
      r_zeros    <= '0;
      r_prev     <= 1'b0;
      configured <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (r_state)
        S_CFG_N, S_CFG_KEY, S_CFG_MASK: begin
          if (mode) begin
            r_cfg_cnt <= w_cfg_last ? '0 : r_cfg_cnt + c_CW'(1);
            if (r_state == S_CFG_N) begin
              r_n <= {r_n[N_W-2:0], str};
              if (w_cfg_last) begin
                r_d    <= '0;
                r_caps <= '0;
              end
            end else if (r_state == S_CFG_KEY) begin
              r_d <= {r_d[KEY_W-2:0], str};
            end else begin
              r_caps <= {r_caps[KEY_W-2:0], str};
              if (w_cfg_last) begin
                configured <= 1'b1;
                r_prev     <= 1'b0;
              end
            end
          end
        end
        default: begin
          // The mode=1 cycle that aborts reception is a restart trigger, not a config bit.
          if (mode) begin
            configured <= 1'b0;
            r_cfg_cnt  <= '0;
            r_period   <= '0;
            r_ones     <= '0;
            r_zeros    <= '0;
            r_prev     <= 1'b0;
          end else begin
            r_prev <= str;
            if (r_state != S_RX) begin
              if (w_edge) begin
                r_period <= CNT_W'(1);
                r_ones   <= CNT_W'(1);
                r_zeros  <= '0;
              end
            end else if (w_qual) begin
              r_period <= CNT_W'(1);
              r_ones   <= CNT_W'(1);
              r_zeros  <= '0;
            end else if (w_tout) begin
              timeout <= 1'b1;
            end else begin
              r_period <= sat_inc(r_period);
              if (str) r_ones  <= sat_inc(r_ones);
              else     r_zeros <= sat_inc(r_zeros);
            end
          end
        end
      endcase
    end
  end

  // One-entry output buffer; a word arriving while full and not popped is lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      msg       <= '0;
      msg_valid <= 1'b0;
      bit_out   <= 1'b0;
      frame     <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      frame <= w_qual;
      if (w_qual) begin
        if (!msg_valid || msg_ready) begin
          msg       <= w_word;
          bit_out   <= w_bit;
          msg_valid <= 1'b1;
        end else begin
          overflow <= 1'b1;
        end
      end else if (msg_valid && msg_ready) begin
        msg_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
